adc_avg_mon: RTL and testbench

//  Downstream consumer of the SPI ADC receiver. Captures each completed sample (vd on vd_rdy rise).
//  Box-car averages 2^AVG_LOG2 samples and publishes the mean with a 1-cycle valid strobe.

---
 rtl/adc_avg_mon_pkg.sv | 21 ++
 rtl/adc_avg_mon_if.sv | 24 ++
 rtl/sync_edge.sv | 27 ++
 rtl/adc_avg_mon.sv | 136 +++++++++++++
 tb/tb_adc_avg_mon.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/adc_avg_mon_pkg.sv
// Shared constants and helpers for the ADC averaging monitor and its CDC edge detector.
package adc_avg_mon_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_WAIT    = 2'd0;
  localparam logic [1:0] ST_ACCUM   = 2'd1;
  localparam logic [1:0] ST_PUBLISH = 2'd2;

  // Synchroniser depth for asynchronous strobes
  localparam int unsigned SYNC_DEPTH = 2;

  // Violation counter width; covers FAULT_CNT up to 15
  localparam int unsigned FAULT_CW = 4;

  // Saturating increment for the violation counters
  function automatic logic [FAULT_CW-1:0] sat_inc(input logic [FAULT_CW-1:0] c,
                                                  input logic [FAULT_CW-1:0] lim);
    return (c >= lim) ? lim : c + FAULT_CW'(1);
  endfunction

endpackage

// File: rtl/adc_avg_mon_if.sv
// Sample, limit and status bundle between the SPI ADC side and the averaging monitor.
interface adc_avg_mon_if #(
  parameter int unsigned ADC_WIDTH = 8
);
  logic                 vd_rdy;
  logic [ADC_WIDTH-1:0] vd;
  logic [ADC_WIDTH-1:0] ov_limit;
  logic [ADC_WIDTH-1:0] uv_limit;
  logic                 fault_clr;
  logic [ADC_WIDTH-1:0] avg;
  logic                 avg_valid;
  logic                 ov_fault;
  logic                 uv_fault;

  modport master (
    output vd_rdy, vd, ov_limit, uv_limit, fault_clr,
    input  avg, avg_valid, ov_fault, uv_fault
  );

  modport slave (
    input  vd_rdy, vd, ov_limit, uv_limit, fault_clr,
    output avg, avg_valid, ov_fault, uv_fault
  );
endinterface

// File: rtl/sync_edge.sv
// Synchronises an asynchronous level and emits a 1-cycle pulse on its rising edge.
module sync_edge
  import adc_avg_mon_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;

  // Synchroniser chain, previous-value flop and registered edge pulse
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_DEPTH-2:0], async_in};
      prev_q     <= sync_q[SYNC_DEPTH-1];
      rise_pulse <= sync_q[SYNC_DEPTH-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/adc_avg_mon.sv
// Box-car averager of ADC samples with sticky over/under-voltage fault detection.
module adc_avg_mon
  import adc_avg_mon_pkg::*;
#(
  parameter int unsigned ADC_WIDTH = 8,
  parameter int unsigned AVG_LOG2  = 2,
  parameter int unsigned FAULT_CNT = 3
) (
  input  logic          clk,
  input  logic          n_rst,
  adc_avg_mon_if.slave  bus
);

  localparam int unsigned SUM_W = ADC_WIDTH + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0]    SAMPLES = CNT_W'(1 << AVG_LOG2);
  localparam logic [FAULT_CW-1:0] FC_MAX  = FAULT_CW'(FAULT_CNT);

  logic                 samp_stb;
  logic [1:0]           state_q, state_d;
  logic [SUM_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADC_WIDTH-1:0] avg_q, avg_d;
  logic                 avg_valid_q, avg_valid_d;
  logic [FAULT_CW-1:0]  ov_cnt_q, ov_cnt_d;
  logic [FAULT_CW-1:0]  uv_cnt_q, uv_cnt_d;
  logic                 ov_fault_q, ov_fault_d;
  logic                 uv_fault_q, uv_fault_d;

  logic [SUM_W-1:0]     sum_c;
  logic [CNT_W-1:0]     cnt_inc_c;
  logic [ADC_WIDTH-1:0] avg_new_c;
  logic                 publish_c;
  logic                 ov_set_c;
  logic                 uv_set_c;

  // Detect completed samples from the asynchronous ready line
  sync_edge u_sync (
    .clk        (clk),
    .n_rst      (n_rst),
    .async_in   (bus.vd_rdy),
    .rise_pulse (samp_stb)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_WAIT;
      acc_q       <= '0;
      cnt_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      ov_cnt_q    <= '0;
      uv_cnt_q    <= '0;
      ov_fault_q  <= 1'b0;
      uv_fault_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      ov_cnt_q    <= ov_cnt_d;
      uv_cnt_q    <= uv_cnt_d;
      ov_fault_q  <= ov_fault_d;
      uv_fault_q  <= uv_fault_d;
    end
  end

  // Next-state, accumulation, publish and fault logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    ov_cnt_d    = ov_cnt_q;
    uv_cnt_d    = uv_cnt_q;
    ov_fault_d  = ov_fault_q;
    uv_fault_d  = uv_fault_q;
    publish_c   = 1'b0;

    // A new window starts from the incoming sample alone
    sum_c     = (state_q == ST_ACCUM) ? acc_q + SUM_W'(bus.vd) : SUM_W'(bus.vd);
    cnt_inc_c = (state_q == ST_ACCUM) ? cnt_q + CNT_W'(1) : CNT_W'(1);
    avg_new_c = ADC_WIDTH'(sum_c >> AVG_LOG2);

    case (state_q)
      ST_WAIT, ST_ACCUM: begin
        if (samp_stb) begin
          acc_d = sum_c;
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == SAMPLES) begin
            publish_c = 1'b1;
            state_d   = ST_PUBLISH;
          end else begin
            state_d   = ST_ACCUM;
          end
        end
      end
      ST_PUBLISH: state_d = ST_WAIT;
      default:    state_d = ST_WAIT;
    endcase

    // Average is registered on entry so avg_valid coincides with the PUBLISH cycle
    if (publish_c) begin
      avg_d       = avg_new_c;
      avg_valid_d = 1'b1;
      ov_cnt_d    = (avg_new_c > bus.ov_limit) ? sat_inc(ov_cnt_q, FC_MAX) : '0;
      uv_cnt_d    = (avg_new_c < bus.uv_limit) ? sat_inc(uv_cnt_q, FC_MAX) : '0;
    end

    // Faults latch only on a fresh average that left a counter at threshold
    ov_set_c = (state_q == ST_PUBLISH) && (ov_cnt_q == FC_MAX);
    uv_set_c = (state_q == ST_PUBLISH) && (uv_cnt_q == FC_MAX);

    if (bus.fault_clr) begin
      ov_cnt_d   = '0;
      uv_cnt_d   = '0;
      ov_fault_d = 1'b0;
      uv_fault_d = 1'b0;
    end
    if (ov_set_c) ov_fault_d = 1'b1;
    if (uv_set_c) uv_fault_d = 1'b1;
  end

  assign bus.avg       = avg_q;
  assign bus.avg_valid = avg_valid_q;
  assign bus.ov_fault  = ov_fault_q;
  assign bus.uv_fault  = uv_fault_q;

  // Sample spacing guarantees no capture can land in the single PUBLISH cycle
  a_no_stb_in_publish: assert property (@(posedge clk) disable iff (!n_rst)
    !(samp_stb && (state_q == ST_PUBLISH)));

endmodule

// File: tb/tb_adc_avg_mon.sv
// Directed bench for adc_avg_mon: averaging, latency, faults, reset and async capture.
module tb_adc_avg_mon;

  logic clk;
  logic n_rst;

  int n_chk = 0;
  int n_err = 0;
  int vcnt  = 0;
  int vcnt0 = 0;
  logic [7:0] last_avg;
  logic [7:0] last_avg0;

  adc_avg_mon_if #(.ADC_WIDTH(8)) bus  ();
  adc_avg_mon_if #(.ADC_WIDTH(8)) bus0 ();

  adc_avg_mon #(.ADC_WIDTH(8), .AVG_LOG2(2), .FAULT_CNT(3)) u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  adc_avg_mon #(.ADC_WIDTH(8), .AVG_LOG2(0), .FAULT_CNT(3)) u_dut0 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count published averages away from the active edge
  always @(negedge clk) begin
    if (bus.avg_valid === 1'b1) begin
      vcnt++;
      last_avg = bus.avg;
    end
    if (bus0.avg_valid === 1'b1) begin
      vcnt0++;
      last_avg0 = bus0.avg;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One vd_rdy pulse: rise ph ns after a clk edge, held hi clk, 20 clk per sample.
  // lat = number of clk edges from the rise until avg_valid is seen (-1 if none).
  task automatic send(input bit sel, input logic [7:0] val, input int ph, input int hi,
                      input int clr_k, output int lat);
    lat = -1;
    @(posedge clk);
    #ph;
    if (sel) begin
      bus0.vd     = val;
      bus0.vd_rdy = 1'b1;
    end else begin
      bus.vd      = val;
      bus.vd_rdy  = 1'b1;
    end
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == hi) begin
        bus.vd_rdy  = 1'b0;
        bus0.vd_rdy = 1'b0;
      end
      if (k == clr_k) bus0.fault_clr = 1'b1;
      else if (k == clr_k + 1) bus0.fault_clr = 1'b0;
      if (lat < 0 && ((sel ? bus0.avg_valid : bus.avg_valid) === 1'b1)) lat = k;
    end
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    bus0.fault_clr = 1'b1;
    @(posedge clk);
    #1;
    bus0.fault_clr = 1'b0;
  endtask

  initial begin
    int lat;
    int base;
    logic [7:0] v;
    logic [7:0] t1_vals [4];
    logic [7:0] t3_vals [6];
    t1_vals = '{8'd10, 8'd20, 8'd30, 8'd40};
    t3_vals = '{8'h90, 8'h90, 8'h70, 8'h90, 8'h90, 8'h90};

    n_rst = 1'b0;
    bus.vd_rdy = 1'b0;  bus.vd = '0;  bus.fault_clr = 1'b0;
    bus.ov_limit = 8'hFF;  bus.uv_limit = 8'h00;
    bus0.vd_rdy = 1'b0; bus0.vd = '0; bus0.fault_clr = 1'b0;
    bus0.ov_limit = 8'hFF; bus0.uv_limit = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_avg", 32'(bus.avg), 32'd0);
    chk("rst_valid", 32'(bus.avg_valid), 32'd0);
    chk("rst_ov", 32'(bus.ov_fault), 32'd0);
    chk("rst_uv", 32'(bus.uv_fault), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // Four samples make one average; latency measured on the last one
    for (int i = 0; i < 4; i++) begin
      send(1'b0, t1_vals[i], 2 + 2 * i, 5, 0, lat);
      if (i == 2) chk("t1_no_early_valid", 32'(vcnt), 32'd0);
    end
    chk("t1_latency", 32'(lat), 32'd4);
    chk("t1_count", 32'(vcnt), 32'd1);
    chk("t1_avg", 32'(last_avg), 32'd25);

    // Pass-through instance: all-ones every sample, equal to ov_limit
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 8'hFF, 3, 5, 0, lat);
      if (i == 0) chk("t2_latency", 32'(lat), 32'd4);
    end
    chk("t2_count", 32'(vcnt0), 32'd8);
    chk("t2_avg", 32'(last_avg0), 32'hFF);
    chk("t2_ov_at_limit", 32'(bus0.ov_fault), 32'd0);

    // Consecutive violations; the in-range value restarts the run
    bus0.ov_limit = 8'h80;
    bus0.uv_limit = 8'h10;
    for (int i = 0; i < 6; i++) begin
      send(1'b1, t3_vals[i], 4, 5, 0, lat);
      if (i == 4) chk("t3_ov_before_6th", 32'(bus0.ov_fault), 32'd0);
    end
    chk("t3_ov_after_6th", 32'(bus0.ov_fault), 32'd1);
    chk("t3_uv_quiet", 32'(bus0.uv_fault), 32'd0);

    // Sticky until cleared
    for (int i = 0; i < 3; i++) send(1'b1, 8'h50, 6, 5, 0, lat);
    chk("t4_sticky", 32'(bus0.ov_fault), 32'd1);
    clr_pulse();
    chk("t4_cleared", 32'(bus0.ov_fault), 32'd0);

    // Clear during the third violating publish: set wins, counters restart
    send(1'b1, 8'h90, 2, 5, 0, lat);
    send(1'b1, 8'h90, 2, 5, 0, lat);
    send(1'b1, 8'h90, 2, 5, 4, lat);
    chk("t4_set_wins", 32'(bus0.ov_fault), 32'd1);
    clr_pulse();
    chk("t4_cleared2", 32'(bus0.ov_fault), 32'd0);
    send(1'b1, 8'h90, 7, 5, 0, lat);
    send(1'b1, 8'h90, 7, 5, 0, lat);
    chk("t4_cnt_restarted", 32'(bus0.ov_fault), 32'd0);

    // Averages exactly at each limit count as in range
    for (int i = 0; i < 3; i++) send(1'b1, 8'h80, 1, 4, 0, lat);
    chk("t6_ov_eq_limit", 32'(bus0.ov_fault), 32'd0);
    for (int i = 0; i < 3; i++) send(1'b1, 8'h10, 8, 6, 0, lat);
    chk("t6_uv_eq_limit", 32'(bus0.uv_fault), 32'd0);
    for (int i = 0; i < 3; i++) send(1'b1, 8'h05, 5, 5, 0, lat);
    chk("t6_uv_set", 32'(bus0.uv_fault), 32'd1);
    chk("t6_ov_quiet", 32'(bus0.ov_fault), 32'd0);

    // Random phase and width: exactly one capture per pulse
    bus0.ov_limit = 8'hFF;
    bus0.uv_limit = 8'h00;
    base = vcnt0;
    for (int i = 0; i < 10; i++) begin
      v = 8'($urandom_range(0, 255));
      send(1'b1, v, int'($urandom_range(1, 9)), int'($urandom_range(4, 6)), 0, lat);
      chk("t6_cdc_avg", 32'(last_avg0), 32'(v));
    end
    chk("t6_cdc_count", 32'(vcnt0 - base), 32'd10);
    chk("t6_uv_sticky", 32'(bus0.uv_fault), 32'd1);

    // Reset in the middle of a window discards the partial sum
    send(1'b0, 8'd100, 3, 5, 0, lat);
    send(1'b0, 8'd200, 3, 5, 0, lat);
    base = vcnt;
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("t5_rst_avg", 32'(bus.avg), 32'd0);
    chk("t5_rst_valid", 32'(bus.avg_valid), 32'd0);
    chk("t5_rst_uv0", 32'(bus0.uv_fault), 32'd0);
    chk("t5_rst_avg0", 32'(bus0.avg), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b0, 8'd8, 5, 5, 0, lat);
    chk("t5_count", 32'(vcnt - base), 32'd1);
    chk("t5_avg", 32'(last_avg), 32'd8);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
